// File: rtl/dma_pkg.sv
// Shared types for the DMA engine: FSM state encoding, command codes and
// the default DRAM stride.
`timescale 1ns/1ps
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        D2S_REQ,
        D2S_WR,
        S2D_RD,
        S2D_REQ,
        STEP,
        DONE
    } state_t;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_D2S  = 2'b01;
    localparam logic [1:0] CMD_S2D  = 2'b10;
    localparam logic [1:0] CMD_RSVD = 2'b11;

    localparam logic [15:0] DRAM_STRIDE_DEFAULT = 16'd4;

endpackage

// File: rtl/dma_if.sv
// Command, SRAM and DRAM signals of the DMA engine. The optional dramStride
// input exists only when DMA_STRIDE_EN is defined.
`timescale 1ns/1ps
interface dma_if #(
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 14,
    parameter int LEN_W   = 10
);
    logic [1:0]         cmd;
    logic [31:0]        srcAddress;
    logic [31:0]        dstAddress;
    logic [LEN_W-1:0]   width;
`ifdef DMA_STRIDE_EN
    logic [15:0]        dramStride;
`endif
    logic [SRAM_AW-1:0] sramAddress;
    logic [DATA_W-1:0]  sramReadData;
    logic [DATA_W-1:0]  sramWriteData;
    logic               sramWriteEnable;
    logic [31:0]        dramAddress;
    logic [DATA_W-1:0]  dramWriteData;
    logic               dramReadEnable;
    logic               dramWriteEnable;
    logic [DATA_W-1:0]  dramReadData;
    logic               dramValid;
    logic               stall;
    logic               done;

    // The DMA engine side
    modport master (
        input  cmd, srcAddress, dstAddress, width,
`ifdef DMA_STRIDE_EN
        input  dramStride,
`endif
        input  sramReadData, dramReadData, dramValid,
        output sramAddress, sramWriteData, sramWriteEnable,
        output dramAddress, dramWriteData, dramReadEnable, dramWriteEnable,
        output stall, done
    );

    // Host and memory side
    modport slave (
        output cmd, srcAddress, dstAddress, width,
`ifdef DMA_STRIDE_EN
        output dramStride,
`endif
        output sramReadData, dramReadData, dramValid,
        input  sramAddress, sramWriteData, sramWriteEnable,
        input  dramAddress, dramWriteData, dramReadEnable, dramWriteEnable,
        input  stall, done
    );
endinterface

// File: rtl/dma_addr_gen.sv
// Source/destination address and remaining-count registers. The DRAM-side
// address advances by the latched stride, the SRAM side always by 4 bytes.
`timescale 1ns/1ps
module dma_addr_gen #(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             dram_is_src,
    input  logic [31:0]      src_in,
    input  logic [31:0]      dst_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [15:0]      stride_in,
    output logic [31:0]      src_addr,
    output logic [31:0]      dst_addr,
    output logic [LEN_W-1:0] remaining,
    output logic             last
);
    logic [31:0]      src_reg;
    logic [31:0]      dst_reg;
    logic [LEN_W-1:0] remaining_reg;
    logic [15:0]      stride_reg;
    logic [31:0]      src_inc;
    logic [31:0]      dst_inc;

    assign src_inc = dram_is_src ? {16'd0, stride_reg} : 32'd4;
    assign dst_inc = dram_is_src ? 32'd4 : {16'd0, stride_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_reg       <= '0;
            dst_reg       <= '0;
            remaining_reg <= '0;
            stride_reg    <= '0;
        end else if (load) begin
            src_reg       <= src_in;
            dst_reg       <= dst_in;
            remaining_reg <= len_in;
            stride_reg    <= stride_in;
        end else if (step) begin
            src_reg       <= src_reg + src_inc;
            dst_reg       <= dst_reg + dst_inc;
            remaining_reg <= remaining_reg - LEN_W'(1);
        end
    end

    assign src_addr  = src_reg;
    assign dst_addr  = dst_reg;
    assign remaining = remaining_reg;
    // The word being stepped is the final one
    assign last      = (remaining_reg == LEN_W'(1));
endmodule

// File: rtl/dma_engine.sv
// Word-by-word DMA between DRAM (byte addressed, request/valid) and SRAM
// (word addressed, one-cycle read). Define DMA_STRIDE_EN for a DRAM byte stride.
`timescale 1ns/1ps
module dma_engine
    import dma_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 14,
    parameter int LEN_W   = 10
) (
    input logic   clk,
    input logic   reset_n,
    dma_if.master bus
);
    state_t            state_reg;
    logic              dir_s2d_reg;
    logic              first_reg;
    logic [DATA_W-1:0] data_reg;
    logic              rd_en_reg;
    logic              wr_en_reg;
    logic              sram_we_reg;
    logic              done_reg;
    logic              stall_reg;

    logic [31:0]       src_addr;
    logic [31:0]       dst_addr;
    logic [LEN_W-1:0]  remaining;
    logic              last;
    logic [15:0]       stride_in;

`ifdef DMA_STRIDE_EN
    assign stride_in = bus.dramStride;
`else
    assign stride_in = DRAM_STRIDE_DEFAULT;
`endif

    dma_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (state_reg == LOAD),
        .step        (state_reg == STEP),
        .dram_is_src (!dir_s2d_reg),
        .src_in      (bus.srcAddress),
        .dst_in      (bus.dstAddress),
        .len_in      (bus.width),
        .stride_in   (stride_in),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .remaining   (remaining),
        .last        (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            dir_s2d_reg <= 1'b0;
            first_reg   <= 1'b0;
            data_reg    <= '0;
            rd_en_reg   <= 1'b0;
            wr_en_reg   <= 1'b0;
            sram_we_reg <= 1'b0;
            done_reg    <= 1'b0;
            stall_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cmd == CMD_D2S || bus.cmd == CMD_S2D) begin
                        state_reg   <= LOAD;
                        dir_s2d_reg <= (bus.cmd == CMD_S2D);
                        stall_reg   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.width == '0) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else if (dir_s2d_reg) begin
                        state_reg <= S2D_RD;
                    end else begin
                        state_reg <= D2S_REQ;
                        rd_en_reg <= 1'b1;
                    end
                end
                D2S_REQ: begin
                    if (bus.dramValid) begin
                        data_reg    <= bus.dramReadData;
                        rd_en_reg   <= 1'b0;
                        sram_we_reg <= 1'b1;
                        state_reg   <= D2S_WR;
                    end
                end
                D2S_WR: begin
                    sram_we_reg <= 1'b0;
                    state_reg   <= STEP;
                end
                S2D_RD: begin
                    wr_en_reg <= 1'b1;
                    first_reg <= 1'b1;
                    state_reg <= S2D_REQ;
                end
                S2D_REQ: begin
                    // SRAM data appears on the cycle after the address was driven
                    if (first_reg) begin
                        data_reg  <= bus.sramReadData;
                        first_reg <= 1'b0;
                    end
                    if (bus.dramValid) begin
                        wr_en_reg <= 1'b0;
                        state_reg <= STEP;
                    end
                end
                STEP: begin
                    if (last) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else if (dir_s2d_reg) begin
                        state_reg <= S2D_RD;
                    end else begin
                        state_reg <= D2S_REQ;
                        rd_en_reg <= 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    stall_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.dramAddress     = dir_s2d_reg ? dst_addr : src_addr;
    assign bus.sramAddress     = dir_s2d_reg ? src_addr[SRAM_AW+1:2] : dst_addr[SRAM_AW+1:2];
    assign bus.sramWriteData   = data_reg;
    // Forward the fresh SRAM word until it has been captured
    assign bus.dramWriteData   = first_reg ? bus.sramReadData : data_reg;
    assign bus.dramReadEnable  = rd_en_reg;
    assign bus.dramWriteEnable = wr_en_reg;
    assign bus.sramWriteEnable = sram_we_reg;
    assign bus.done            = done_reg;
    assign bus.stall           = stall_reg;

    logic unused_ok;
    assign unused_ok = ^remaining;
endmodule

// File: tb/tb_dma_engine.sv
// Directed testbench for dma_engine with an SRAM model (one-cycle read) and a
// DRAM model answering each request after two cycles with data = addr + 0xCAFE0000.
`timescale 1ns/1ps
module tb_dma_engine;
    import dma_pkg::*;

    localparam int DATA_W  = 32;
    localparam int SRAM_AW = 14;
    localparam int LEN_W   = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    dma_if #(.DATA_W(DATA_W), .SRAM_AW(SRAM_AW), .LEN_W(LEN_W)) bus ();

    dma_engine #(.DATA_W(DATA_W), .SRAM_AW(SRAM_AW), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] sram_mem [0:(1<<SRAM_AW)-1];

    always @(posedge clk) bus.sramReadData <= sram_mem[bus.sramAddress];

    logic [1:0] lat_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt          <= '0;
            bus.dramValid    <= 1'b0;
            bus.dramReadData <= '0;
        end else begin
            bus.dramValid <= 1'b0;
            if ((bus.dramReadEnable || bus.dramWriteEnable) && !bus.dramValid) begin
                if (lat_cnt == 2'd1) begin
                    bus.dramValid    <= 1'b1;
                    bus.dramReadData <= bus.dramAddress + 32'hCAFE_0000;
                    lat_cnt          <= '0;
                end else begin
                    lat_cnt <= lat_cnt + 2'd1;
                end
            end else begin
                lat_cnt <= '0;
            end
        end
    end

    logic [31:0] sw_addr_q [$];
    logic [31:0] sw_data_q [$];
    logic [31:0] dw_addr_q [$];
    logic [31:0] dw_data_q [$];
    logic [31:0] dr_addr_q [$];
    int done_cnt, rd_hi_cnt, wr_hi_cnt, both_cnt, rd_rise_cnt;
    logic rd_prev = 1'b0;

    always @(posedge clk) begin
        if (reset_n) begin
            if (bus.sramWriteEnable) begin
                sw_addr_q.push_back(32'(bus.sramAddress));
                sw_data_q.push_back(bus.sramWriteData);
                $display("%0t sram_write addr=%h data=%h", $time, bus.sramAddress, bus.sramWriteData);
            end
            if (bus.dramValid && bus.dramWriteEnable) begin
                dw_addr_q.push_back(bus.dramAddress);
                dw_data_q.push_back(bus.dramWriteData);
                $display("%0t dram_write addr=%h data=%h", $time, bus.dramAddress, bus.dramWriteData);
            end
            if (bus.dramValid && bus.dramReadEnable) begin
                dr_addr_q.push_back(bus.dramAddress);
                $display("%0t dram_read  addr=%h data=%h", $time, bus.dramAddress, bus.dramReadData);
            end
            if (bus.done) done_cnt++;
            if (bus.dramReadEnable) rd_hi_cnt++;
            if (bus.dramWriteEnable) wr_hi_cnt++;
            if (bus.dramReadEnable && bus.dramWriteEnable) both_cnt++;
            if (bus.dramReadEnable && !rd_prev) rd_rise_cnt++;
        end
        rd_prev = bus.dramReadEnable;
    end

    task automatic clear_logs();
        sw_addr_q.delete(); sw_data_q.delete();
        dw_addr_q.delete(); dw_data_q.delete(); dr_addr_q.delete();
        done_cnt = 0; rd_hi_cnt = 0; wr_hi_cnt = 0; both_cnt = 0; rd_rise_cnt = 0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [31:0] s, input logic [31:0] d,
                         input logic [LEN_W-1:0] w, input logic [15:0] stride);
        @(negedge clk);
        bus.cmd = c; bus.srcAddress = s; bus.dstAddress = d; bus.width = w;
`ifdef DMA_STRIDE_EN
        bus.dramStride = stride;
`else
        if (stride != 16'd4) $display("stride %0d ignored in this build", stride);
`endif
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            bus.cmd = CMD_NONE;
            if (done_cnt != 0) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.cmd = CMD_NONE; bus.srcAddress = '0; bus.dstAddress = '0; bus.width = '0;
`ifdef DMA_STRIDE_EN
        bus.dramStride = 16'd4;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b0) begin
            failures++; $display("FAIL reset_status: stall=%b done=%b expected 0 0", bus.stall, bus.done);
        end
        checks++;
        if (bus.dramReadEnable !== 1'b0 || bus.dramWriteEnable !== 1'b0 || bus.sramWriteEnable !== 1'b0) begin
            failures++; $display("FAIL reset_enables: rd=%b wr=%b swe=%b expected 000",
                                 bus.dramReadEnable, bus.dramWriteEnable, bus.sramWriteEnable);
        end
        checks++;
        if (bus.dramAddress !== 32'h0 || bus.sramAddress !== '0) begin
            failures++; $display("FAIL reset_addr: dram=%h sram=%h expected 0 0", bus.dramAddress, bus.sramAddress);
        end
        reset_n = 1'b1;
        @(negedge clk);
        clear_logs();
    endtask

    task automatic test_d2s();
        logic [31:0] exp_sa [3] = '{32'h10, 32'h11, 32'h12};
        logic [31:0] exp_sd [3] = '{32'hCAFE_1000, 32'hCAFE_1004, 32'hCAFE_1008};
        logic [31:0] exp_ra [3] = '{32'h1000, 32'h1004, 32'h1008};
        logic [31:0] got_a, got_d, got_r;
        clear_logs();
        issue(CMD_D2S, 32'h1000, 32'h0040, 10'd3, 16'd4);
        wait_done(200);
        checks++;
        if (sw_addr_q.size() != 3) begin
            failures++; $display("FAIL d2s_count: sram writes=%0d expected 3", sw_addr_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got_a = (i < sw_addr_q.size()) ? sw_addr_q[i] : 32'hFFFF_FFFF;
            got_d = (i < sw_data_q.size()) ? sw_data_q[i] : 32'hFFFF_FFFF;
            got_r = (i < dr_addr_q.size()) ? dr_addr_q[i] : 32'hFFFF_FFFF;
            checks++;
            if (got_a !== exp_sa[i] || got_d !== exp_sd[i] || got_r !== exp_ra[i]) begin
                failures++; $display("FAIL d2s_word%0d: sram %h<=%h dram_rd %h expected sram %h<=%h dram_rd %h",
                                     i, got_a, got_d, got_r, exp_sa[i], exp_sd[i], exp_ra[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || bus.stall !== 1'b0 || wr_hi_cnt != 0) begin
            failures++; $display("FAIL d2s_end: done=%0d stall=%b wr_cycles=%0d expected 1 0 0",
                                 done_cnt, bus.stall, wr_hi_cnt);
        end
    endtask

    task automatic test_s2d();
        logic [31:0] exp_a [2] = '{32'h2000, 32'h2004};
        logic [31:0] exp_d [2] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A};
        logic [31:0] got_a, got_d;
        clear_logs();
        sram_mem[0] = 32'hA5A5_A5A5;
        sram_mem[1] = 32'h5A5A_5A5A;
        issue(CMD_S2D, 32'h0000, 32'h2000, 10'd2, 16'd4);
        wait_done(200);
        checks++;
        if (dw_addr_q.size() != 2 || rd_hi_cnt != 0 || done_cnt != 1) begin
            failures++; $display("FAIL s2d_count: writes=%0d rd_cycles=%0d done=%0d expected 2 0 1",
                                 dw_addr_q.size(), rd_hi_cnt, done_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            got_a = (i < dw_addr_q.size()) ? dw_addr_q[i] : 32'hFFFF_FFFF;
            got_d = (i < dw_data_q.size()) ? dw_data_q[i] : 32'hFFFF_FFFF;
            checks++;
            if (got_a !== exp_a[i] || got_d !== exp_d[i]) begin
                failures++; $display("FAIL s2d_word%0d: dram %h<=%h expected %h<=%h",
                                     i, got_a, got_d, exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        issue(CMD_D2S, 32'h1000, 32'h0040, 10'd0, 16'd4);
        @(negedge clk);
        bus.cmd = CMD_NONE;
        checks++;
        if (bus.done !== 1'b0 || bus.stall !== 1'b1) begin
            failures++; $display("FAIL zero_len_c1: done=%b stall=%b expected 0 1", bus.done, bus.stall);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++; $display("FAIL zero_len_c2: done=%b expected 1", bus.done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || rd_hi_cnt != 0 || wr_hi_cnt != 0 || sw_addr_q.size() != 0 || done_cnt != 1) begin
            failures++; $display("FAIL zero_len_end: stall=%b rd=%0d wr=%0d sram_wr=%0d done=%0d expected 0 0 0 0 1",
                                 bus.stall, rd_hi_cnt, wr_hi_cnt, sw_addr_q.size(), done_cnt);
        end
    endtask

    task automatic test_no_restart();
        logic [31:0] got_a, got_d;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            sram_mem[32'h40 + i] = 32'h0000_B000 + 32'(i);
            sram_mem[32'h80 + i] = 32'h0BAD_0000 + 32'(i);
        end
        issue(CMD_S2D, 32'h0100, 32'h4000, 10'd4, 16'd4);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done) begin
                bus.cmd = CMD_NONE;
                break;
            end
            if (i == 5) begin
                bus.srcAddress = 32'h0200;
                bus.width = 10'd7;
            end
        end
        bus.cmd = CMD_NONE;
        repeat (5) @(negedge clk);
        checks++;
        if (dw_addr_q.size() != 4 || done_cnt != 1 || bus.stall !== 1'b0) begin
            failures++; $display("FAIL norestart_count: writes=%0d done=%0d stall=%b expected 4 1 0",
                                 dw_addr_q.size(), done_cnt, bus.stall);
        end
        for (int i = 0; i < 4; i++) begin
            got_a = (i < dw_addr_q.size()) ? dw_addr_q[i] : 32'hFFFF_FFFF;
            got_d = (i < dw_data_q.size()) ? dw_data_q[i] : 32'hFFFF_FFFF;
            checks++;
            if (got_a !== 32'h4000 + 32'(4*i) || got_d !== 32'h0000_B000 + 32'(i)) begin
                failures++; $display("FAIL norestart_word%0d: dram %h<=%h expected %h<=%h",
                                     i, got_a, got_d, 32'h4000 + 32'(4*i), 32'h0000_B000 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        issue(CMD_D2S, 32'h0500, 32'h0000, 10'd5, 16'd4);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.cmd = CMD_NONE;
            if (rd_rise_cnt == 2) break;
        end
        checks++;
        if (bus.dramReadEnable !== 1'b1) begin
            failures++; $display("FAIL midreset_setup: rd=%b expected 1 before reset", bus.dramReadEnable);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.dramReadEnable !== 1'b0 || bus.stall !== 1'b0 || bus.dramAddress !== 32'h0) begin
            failures++; $display("FAIL midreset_drop: rd=%b stall=%b addr=%h expected 0 0 0",
                                 bus.dramReadEnable, bus.stall, bus.dramAddress);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 0 || sw_addr_q.size() != 1) begin
            failures++; $display("FAIL midreset_abort: done=%0d sram_wr=%0d expected 0 1", done_cnt, sw_addr_q.size());
        end
        clear_logs();
        issue(CMD_D2S, 32'h0600, 32'h0080, 10'd1, 16'd4);
        wait_done(200);
        checks++;
        if (sw_addr_q.size() != 1 || done_cnt != 1) begin
            failures++; $display("FAIL midreset_next_count: sram_wr=%0d done=%0d expected 1 1", sw_addr_q.size(), done_cnt);
        end else if (sw_addr_q[0] !== 32'h20 || sw_data_q[0] !== 32'hCAFE_0600) begin
            failures++; $display("FAIL midreset_next_word: sram %h<=%h expected 00000020<=cafe0600",
                                 sw_addr_q[0], sw_data_q[0]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_sa [2] = '{32'h3FFF, 32'h0000};
        logic [31:0] exp_sd [2] = '{32'hCAFD_FFFC, 32'hCAFE_0000};
        logic [31:0] exp_ra [2] = '{32'hFFFF_FFFC, 32'h0000_0000};
        logic [31:0] got_a, got_d, got_r;
        clear_logs();
        issue(CMD_D2S, 32'hFFFF_FFFC, 32'h0000_FFFC, 10'd2, 16'd4);
        wait_done(200);
        for (int i = 0; i < 2; i++) begin
            got_a = (i < sw_addr_q.size()) ? sw_addr_q[i] : 32'hFFFF_FFFF;
            got_d = (i < sw_data_q.size()) ? sw_data_q[i] : 32'hFFFF_FFFF;
            got_r = (i < dr_addr_q.size()) ? dr_addr_q[i] : 32'hFFFF_FFFF;
            checks++;
            if (got_a !== exp_sa[i] || got_d !== exp_sd[i] || got_r !== exp_ra[i]) begin
                failures++; $display("FAIL wrap_word%0d: sram %h<=%h dram_rd %h expected sram %h<=%h dram_rd %h",
                                     i, got_a, got_d, got_r, exp_sa[i], exp_sd[i], exp_ra[i]);
            end
        end
        checks++;
        if (both_cnt != 0 || done_cnt != 1) begin
            failures++; $display("FAIL wrap_end: both_enable_cycles=%0d done=%0d expected 0 1", both_cnt, done_cnt);
        end
    endtask

`ifdef DMA_STRIDE_EN
    task automatic test_stride();
        logic [31:0] exp_ra [3] = '{32'h100, 32'h140, 32'h180};
        logic [31:0] got_a, got_r;
        clear_logs();
        issue(CMD_D2S, 32'h0100, 32'h0300, 10'd3, 16'h0040);
        wait_done(200);
        for (int i = 0; i < 3; i++) begin
            got_a = (i < sw_addr_q.size()) ? sw_addr_q[i] : 32'hFFFF_FFFF;
            got_r = (i < dr_addr_q.size()) ? dr_addr_q[i] : 32'hFFFF_FFFF;
            checks++;
            if (got_a !== 32'hC0 + 32'(i) || got_r !== exp_ra[i]) begin
                failures++; $display("FAIL stride_word%0d: sram_addr %h dram_rd %h expected %h %h",
                                     i, got_a, got_r, 32'hC0 + 32'(i), exp_ra[i]);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << SRAM_AW); i++) sram_mem[i] = '0;
        clear_logs();
        test_reset();
        test_d2s();
        test_s2d();
        test_zero_len();
        test_no_restart();
        test_reset_mid();
        test_wrap();
`ifdef DMA_STRIDE_EN
        test_stride();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
